// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception report going in,
// stall vector, flush/redirect, watchdog flag and stall counter coming out.
//   master : drives requests/exception/clear, observes control outputs
//   slave  : pipe_ctrl side
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_from_if;
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic             clr_cnt_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             stall_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
        output excepttype_i, cp0_epc_i, clr_cnt_i,
        input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
        input  excepttype_i, cp0_epc_i, clr_cnt_i,
        output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the six-stage MIPS32 core.
// Merges IF/ID/EX stall requests into a per-stage stall vector, turns MEM
// exception/ERET reports into a one-cycle registered flush with redirect PC,
// and keeps a sticky stall watchdog plus a saturating stall-cycle counter.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_ctrl_if.slave (requests, exception code, EPC, counter clear
//          in; stall vector, flush, redirect PC, timeout, stall count out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation, stall vector live, exceptions accepted
// ST_FLUSH | single flush cycle, stalls forced off, exceptions ignored
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE    = 32'h0000_0020,
    parameter int          STALL_LIMIT = 1024,
    parameter int          CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam int              WD_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(STALL_LIMIT);
    localparam logic [31:0]     ERET_CODE = 32'h0000_000e;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [WD_W-1:0]  wd_left_q, wd_left_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall;

    always_comb begin
        stall = 6'b000000;
        if (!rst && state_q == ST_RUN) begin
            if (bus.stallreq_from_ex) begin
                stall = 6'b001111;
            end else if (bus.stallreq_from_id) begin
                stall = 6'b000111;
            end else if (bus.stallreq_from_if) begin
                stall = 6'b000011;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = 32'h0;
        case (state_q)
            ST_RUN: begin
                if (bus.excepttype_i != 32'h0) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_BASE;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Watchdog is a down-counter holding the stalled cycles still allowed;
    // it trips on the stalled cycle that takes it from 1 to 0 and then parks.
    always_comb begin
        wd_left_d = wd_left_q;
        timeout_d = timeout_q;
        if (stall[0]) begin
            if (wd_left_q != '0) begin
                wd_left_d = wd_left_q - WD_W'(1);
            end
            if (wd_left_q == WD_W'(1)) begin
                timeout_d = 1'b1;
            end
        end else begin
            wd_left_d = WD_LOAD;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt_i) begin
            cnt_d = '0;
        end else if (stall[0] && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            flush_q   <= 1'b0;
            new_pc_q  <= 32'h0;
            wd_left_q <= WD_LOAD;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            wd_left_q <= wd_left_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stall_o         = stall;
    assign bus.flush_o         = flush_q;
    assign bus.new_pc_o        = new_pc_q;
    assign bus.stall_timeout_o = timeout_q;
    assign bus.stall_cnt_o     = cnt_q;
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the six-stage MIPS32 core. It merges stall requests from IF, ID and EX into a per-stage stall vector. It turns exception/ERET reports from MEM into a one-cycle registered flush with a redirect PC. It also keeps a stall watchdog and a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their stall/flush inputs and the PC-register redirect.

## Interface

Parameters:
- EXC_BASE, 32'h0000_0020: redirect target for every exception except ERET.
- STALL_LIMIT, 1024: number of consecutive stalled cycles after which the watchdog trips (≥1).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; everything is registered on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_from_if  in  1  fetch not ready.
- stallreq_from_id  in  1  decode hazard, e.g. a load-use case.
- stallreq_from_ex  in  1  multi-cycle EX operation in progress.
- excepttype_i  in  32  final exception code from MEM; 0 means none.
- cp0_epc_i  in  32  EPC value, already forwarded.
- clr_cnt_i  in  1  clears the stall counter.
- stall_o  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush_o  out  1  kills all pipeline registers; registered.
- new_pc_o  out  32  redirect PC, valid while flush_o=1; registered.
- stall_timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  CNT_W  number of cycles with stall_o[0]=1.

## Operation

**Stall vector** (combinational from the request inputs and the state):
- Priority is EX > ID > IF:
  - EX request: 6'b001111.
  - ID request: 6'b000111.
  - IF request: 6'b000011.
  - No request: 0.
- stall_o is forced to 0 whenever the state is FLUSH.

**States:**
- RUN: normal operation.
  - If excepttype_i≠0, load flush_o=1 and new_pc_o, then go to FLUSH.
- FLUSH: lasts exactly one cycle.
  - flush_o=1.
  - excepttype_i is ignored, because it comes from an instruction being killed.
  - Next state is RUN, with flush_o and new_pc_o cleared to 0.

**new_pc selection** (registered on the RUN→FLUSH edge):
- excepttype_i = 32'h0000_000e (ERET): cp0_epc_i.
- Codes 32'h1 (interrupt), 32'h8 (syscall), 32'ha (invalid instruction), 32'hc (overflow) and 32'hd (trap): EXC_BASE.
- Any other nonzero code: EXC_BASE.

**Watchdog:**
- A run counter counts consecutive cycles with stall_o[0]=1.
- It resets to 0 on any cycle with stall_o[0]=0 and on flush.
- When it reaches STALL_LIMIT, stall_timeout_o is set to 1 and holds until rst.
- The run counter saturates at STALL_LIMIT.

**Performance counter:**
- stall_cnt_o increments on every cycle with stall_o[0]=1.
- It saturates at all-ones and never wraps.
- clr_cnt_i=1 loads 0; clear has priority over increment in the same cycle.

## Timing

- Reset, effective at the clk edge while rst=1:
  - State RUN; flush_o=0; new_pc_o=0; stall_timeout_o=0; stall_cnt_o=0; run counter 0.
  - stall_o=0 during reset regardless of the request inputs.
- Stall latency: 0 cycles. stall_o follows the request inputs in the same cycle.
- Flush latency: excepttype_i≠0 in cycle T gives flush_o=1 and new_pc_o valid in cycle T+1 only. flush_o is never high for two consecutive cycles.
- Back-to-back exceptions:
  - A code present in T+1 (the FLUSH cycle) is dropped.
  - A code present in T+2 triggers a new flush in T+3.
- Exception during a stall: the flush takes effect, and stall_o is 0 in the FLUSH cycle even if requests are still high.
- Reset in the middle of a flush: flush_o=0 in the cycle after rst is sampled high.
- Counters sample the stall_o value of the current cycle. The cycle-N value appears on the outputs in cycle N+1.

## Test plan

- Reset with every input at 1 -> after the reset edge: stall_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0, stall_timeout_o=0.
- stallreq_from_if=1 and stallreq_from_ex=1 in the same cycle -> stall_o=6'b001111. Drop the EX request -> stall_o=6'b000011 in the same cycle.
- excepttype_i=32'h8 for one cycle at T -> flush_o=1 and new_pc_o=32'h20 at T+1; flush_o=0 at T+2.
- excepttype_i=32'he with cp0_epc_i=32'hbfc0_0100 -> new_pc_o=32'hbfc0_0100 for one cycle. A second code held through the FLUSH cycle produces no further flush unless it is still present after the flush.
- With STALL_LIMIT=4: hold stallreq_from_id for 3 cycles, release, then hold for 4 -> stall_timeout_o=1 only after the 4th consecutive stalled cycle, and it stays 1 after release.
- With CNT_W=4: stall for 20 cycles -> stall_cnt_o saturates at 4'hf. Assert clr_cnt_i while still stalled -> stall_cnt_o=0 on the next cycle, then increments again.
